alu_op_sequencer: RTL

//  Registered front/back end for the 32-bit ripple ALU (alu32).

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu32.sv | 63 ++++++
 rtl/alu_op_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Package: alu_pkg
// Purpose: shared widths, alu32 op encoding and sequencer state type.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 4;

  // alu32 control codes
  localparam logic [OP_W-1:0] ADD  = 3'b000;
  localparam logic [OP_W-1:0] SUB  = 3'b001;
  localparam logic [OP_W-1:0] XOR  = 3'b010;
  localparam logic [OP_W-1:0] SLT  = 3'b011;
  localparam logic [OP_W-1:0] AND  = 3'b100;
  localparam logic [OP_W-1:0] NAND = 3'b101;
  localparam logic [OP_W-1:0] NOR  = 3'b110;
  localparam logic [OP_W-1:0] OR   = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/alu32.sv
// Module: alu32
// Purpose: 32-bit combinational ALU (add/sub/slt/logic) with carry, zero and
//          signed-overflow flags.
// Ports:
//   op_i      ALU control code (alu_pkg encoding)
//   a_i, b_i  operands
//   out_c_o   result
//   cout_c_o  carry-out of the adder (ADD/SUB/SLT), 0 for logic ops
//   zout_c_o  result == 0
//   ovf_c_o   signed overflow of the adder (ADD/SUB/SLT), 0 for logic ops
module alu32
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] out_c_o,
  output logic              cout_c_o,
  output logic              zout_c_o,
  output logic              ovf_c_o
);

  logic              sub_c;
  logic [DATA_W-1:0] b_eff_c;
  logic [DATA_W:0]   sum_c;
  logic              add_ovf_c;

  // SUB and SLT share the adder as a + ~b + 1
  assign sub_c     = (op_i == SUB) || (op_i == SLT);
  assign b_eff_c   = sub_c ? ~b_i : b_i;
  assign sum_c     = {1'b0, a_i} + {1'b0, b_eff_c} + (DATA_W+1)'(sub_c);
  assign add_ovf_c = (a_i[DATA_W-1] == b_eff_c[DATA_W-1]) &&
                     (sum_c[DATA_W-1] != a_i[DATA_W-1]);

  // Result mux; adder flags only meaningful for arithmetic ops
  always_comb begin
    out_c_o  = '0;
    cout_c_o = 1'b0;
    ovf_c_o  = 1'b0;
    unique case (op_i)
      ADD, SUB: begin
        out_c_o  = sum_c[DATA_W-1:0];
        cout_c_o = sum_c[DATA_W];
        ovf_c_o  = add_ovf_c;
      end
      SLT: begin
        // signed less-than is the true sign of a-b, i.e. sign xor overflow
        out_c_o  = DATA_W'(sum_c[DATA_W-1] ^ add_ovf_c);
        cout_c_o = sum_c[DATA_W];
        ovf_c_o  = add_ovf_c;
      end
      XOR:     out_c_o = a_i ^ b_i;
      AND:     out_c_o = a_i & b_i;
      NAND:    out_c_o = ~(a_i & b_i);
      NOR:     out_c_o = ~(a_i | b_i);
      OR:      out_c_o = a_i | b_i;
      default: out_c_o = '0;
    endcase
  end

  assign zout_c_o = (out_c_o == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Module: alu_op_sequencer
// Purpose: registered front/back end around alu32. Accepts one op per
//          valid/ready transfer, holds operands for SETTLE_CYCLES clocks,
//          captures the ALU outputs and presents them on a valid/ready port.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      op request handshake (in_ready is combinational)
//   in_op, in_a, in_b      op code and operands
//   res_valid/res_ready    result handshake
//   res_data/cout/zero/ovf captured alu32 outputs
//   ovf_sticky, ovf_clr    sticky overflow flag and its synchronous clear
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_cout,
  output logic              res_zero,
  output logic              res_ovf,
  output logic              ovf_sticky,
  input  logic              ovf_clr
);

  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
    $error("alu_op_sequencer: SETTLE_CYCLES must be within 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_cout_q, res_cout_d;
  logic              res_zero_q, res_zero_d;
  logic              res_ovf_q, res_ovf_d;
  logic              ovf_sticky_q, ovf_sticky_d;

  logic [DATA_W-1:0] alu_out_c;
  logic              alu_cout_c;
  logic              alu_zout_c;
  logic              alu_ovf_c;
  logic              capture_c;

  // ALU sees only the operand registers, so its inputs are stable while settling
  alu32 u_alu (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .out_c_o  (alu_out_c),
    .cout_c_o (alu_cout_c),
    .zout_c_o (alu_zout_c),
    .ovf_c_o  (alu_ovf_c)
  );

  // Ready depends on state and res_ready only, never on in_valid
  assign in_ready = rst_n & ((state_q == IDLE) | ((state_q == DONE) & res_ready));

  assign capture_c = (state_q == SETTLE) && (cnt_q == '0);

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_cout_d   = res_cout_q;
    res_zero_d   = res_zero_q;
    res_ovf_d    = res_ovf_q;
    ovf_sticky_d = ovf_sticky_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          a_d     = in_a;
          b_d     = in_b;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (capture_c) begin
          res_data_d  = alu_out_c;
          res_cout_d  = alu_cout_c;
          res_zero_d  = alu_zout_c;
          res_ovf_d   = alu_ovf_c;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (in_valid) begin
            op_d    = in_op;
            a_d     = in_a;
            b_d     = in_b;
            cnt_d   = CNT_INIT;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear first so a same-edge overflow capture wins
    if (ovf_clr) begin
      ovf_sticky_d = 1'b0;
    end
    if (capture_c && alu_ovf_c) begin
      ovf_sticky_d = 1'b1;
    end
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_cout_q   <= 1'b0;
      res_zero_q   <= 1'b0;
      res_ovf_q    <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_cout_q   <= res_cout_d;
      res_zero_q   <= res_zero_d;
      res_ovf_q    <= res_ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_cout   = res_cout_q;
  assign res_zero   = res_zero_q;
  assign res_ovf    = res_ovf_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule
